// File: rtl/cs_pkg.sv
// Shared colorshield types: pixel payload, address/value widths and arbiter state.
package cs_pkg;

   localparam int unsigned N_PIXELS   = 64;
   localparam int unsigned PIX_ADDR_W = $clog2(N_PIXELS);
   localparam int unsigned PIX_VAL_W  = 24;

   typedef struct packed {
      logic [PIX_ADDR_W-1:0] addr;
      logic [PIX_VAL_W-1:0]  value;
   } pixel_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, with wrap-around.
module rr_pick #(
   parameter int unsigned N     = 2,
   parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     win_oh_o,
   output logic             valid_o
);

   logic [2*N-1:0] req_dbl;
   logic [2*N-1:0] oh_dbl;
   logic [N-1:0]   req_rot;
   logic [N-1:0]   first_oh;
   logic           found;

   // Rotate so that bit 0 is the requester at ptr_i, pick the lowest, rotate back.
   assign req_dbl = {req_i, req_i};
   assign req_rot = N'(req_dbl >> ptr_i);

   always_comb begin
      first_oh = '0;
      found    = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (!found && req_rot[i]) begin
            first_oh[i] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   assign oh_dbl   = {first_oh, first_oh} << ptr_i;
   assign win_oh_o = oh_dbl[2*N-1:N];
   assign valid_o  = |req_i;

endmodule

// File: rtl/cs_write_arbiter.sv
// Round-robin arbiter with per-requester lock sharing the colorshield pixel write port.
// Optional per-requester accepted-write counters under CS_ARB_STATS_EN.
module cs_write_arbiter
   import cs_pkg::*;
#(
   parameter int unsigned N_REQ    = 2,
   parameter int unsigned MAX_LOCK = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ-1:0]            lock,
   input  logic [N_REQ*PIX_ADDR_W-1:0] req_addr,
   input  logic [N_REQ*PIX_VAL_W-1:0]  req_value,
   output logic [N_REQ-1:0]            ack,
   output logic [N_REQ-1:0]            grant,
   input  logic                        cs_ready,
   output logic                        cs_write_en,
   output logic [PIX_ADDR_W-1:0]       cs_pixel_addr,
   output logic [PIX_VAL_W-1:0]        cs_pixel_value,
   output logic                        busy
`ifdef CS_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0]         wr_count
`endif
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_LOCK);

   arb_state_e       state_q, state_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [N_REQ-1:0] lock_oh_q, lock_oh_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic             wr_en_q, wr_en_d;
   pixel_t           pix_q, pix_d;

   logic [N_REQ-1:0] rr_oh;
   logic             rr_vld;
   logic             lock_hit;
   logic [N_REQ-1:0] pick_oh;
   pixel_t           pick_pix;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] nxt_ptr;
   logic             accept;
   logic             lock_keep;

   rr_pick #(.N(N_REQ), .PTR_W(PTR_W)) u_rr_pick (
      .req_i    (req),
      .ptr_i    (rr_ptr_q),
      .win_oh_o (rr_oh),
      .valid_o  (rr_vld)
   );

   // A still-requesting lock owner beats the round-robin choice.
   assign lock_hit = |(req & lock_oh_q);
   assign pick_oh  = lock_hit ? lock_oh_q : rr_oh;

   always_comb begin
      pick_pix = '0;
      win_idx  = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (pick_oh[i]) begin
            pick_pix.addr  = req_addr[i*PIX_ADDR_W +: PIX_ADDR_W];
            pick_pix.value = req_value[i*PIX_VAL_W +: PIX_VAL_W];
         end
         if (grant_q[i]) begin
            win_idx = PTR_W'(i);
         end
      end
   end

   assign nxt_ptr   = (win_idx == PTR_W'(N_REQ-1)) ? '0 : win_idx + PTR_W'(1);
   assign accept    = wr_en_q & cs_ready;
   assign lock_keep = (|(lock & grant_q)) && (lock_cnt_q < CNT_W'(MAX_LOCK-1));
   assign ack       = accept ? grant_q : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         lock_oh_q  <= '0;
         lock_cnt_q <= '0;
         grant_q    <= '0;
         wr_en_q    <= 1'b0;
         pix_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_oh_q  <= lock_oh_d;
         lock_cnt_q <= lock_cnt_d;
         grant_q    <= grant_d;
         wr_en_q    <= wr_en_d;
         pix_q      <= pix_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      lock_oh_d  = lock_oh_q;
      lock_cnt_d = lock_cnt_q;
      grant_d    = grant_q;
      wr_en_d    = wr_en_q;
      pix_d      = pix_q;
      case (state_q)
         IDLE: begin
            wr_en_d = 1'b0;
            if (rr_vld) begin
               // Owner went quiet while others wait: the lock is given up.
               if (!lock_hit) begin
                  lock_oh_d  = '0;
                  lock_cnt_d = '0;
               end
               pix_d   = pick_pix;
               wr_en_d = 1'b1;
               grant_d = pick_oh;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (accept) begin
               wr_en_d = 1'b0;
               grant_d = '0;
               state_d = IDLE;
               if (lock_keep) begin
                  lock_oh_d  = grant_q;
                  lock_cnt_d = lock_cnt_q + CNT_W'(1);
               end else begin
                  lock_oh_d  = '0;
                  lock_cnt_d = '0;
                  rr_ptr_d   = nxt_ptr;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign grant          = grant_q;
   assign cs_write_en    = wr_en_q;
   assign cs_pixel_addr  = pix_q.addr;
   assign cs_pixel_value = pix_q.value;
   assign busy           = (state_q == ISSUE);

`ifdef CS_ARB_STATS_EN
   logic [N_REQ*16-1:0] wr_cnt_q;

   // Saturating count of accepted writes per requester.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_q <= '0;
      end else begin
         for (int i = 0; i < int'(N_REQ); i++) begin
            if (ack[i] && (wr_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
               wr_cnt_q[i*16 +: 16] <= wr_cnt_q[i*16 +: 16] + 16'd1;
            end
         end
      end
   end

   assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_cs_write_arbiter.sv
// Directed and randomized bench for cs_write_arbiter against a transaction-level model.
module tb_cs_write_arbiter;
   import cs_pkg::*;

   localparam int N  = 2;
   localparam int ML = 64;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req;
   logic [N-1:0]      lock;
   logic [N*6-1:0]    req_addr;
   logic [N*24-1:0]   req_value;
   logic [N-1:0]      ack;
   logic [N-1:0]      grant;
   logic              cs_ready;
   logic              cs_write_en;
   logic [5:0]        cs_pixel_addr;
   logic [23:0]       cs_pixel_value;
   logic              busy;
`ifdef CS_ARB_STATS_EN
   logic [N*16-1:0]   wr_count;
`endif

   logic [5:0]  addr_a [N];
   logic [23:0] val_a  [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_addr[i*6 +: 6]    = addr_a[i];
         req_value[i*24 +: 24] = val_a[i];
      end
   end

   cs_write_arbiter #(.N_REQ(N), .MAX_LOCK(ML)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req            (req),
      .lock           (lock),
      .req_addr       (req_addr),
      .req_value      (req_value),
      .ack            (ack),
      .grant          (grant),
      .cs_ready       (cs_ready),
      .cs_write_en    (cs_write_en),
      .cs_pixel_addr  (cs_pixel_addr),
      .cs_pixel_value (cs_pixel_value),
      .busy           (busy)
`ifdef CS_ARB_STATS_EN
      ,
      .wr_count       (wr_count)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: one pending write plus round-robin/lock bookkeeping.
   bit          m_pend;
   int          m_own, m_rr, m_lk, m_lkcnt;
   logic [5:0]  m_addr;
   logic [23:0] m_val;
   int          m_cnt [N];

   int n_pass = 0;
   int n_tot  = 0;
   bit want  [N];
   bit acked [N];
   int ack_log [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] onehot(input int i);
      logic [63:0] v;
      v = 64'd1 << i;
      return v;
   endfunction

   task automatic model_reset();
      m_pend  = 1'b0;
      m_own   = 0;
      m_rr    = 0;
      m_lk    = -1;
      m_lkcnt = 0;
      m_addr  = '0;
      m_val   = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endtask

   task automatic model_step();
      int w;
      if (!m_pend) begin
         if (req != '0) begin
            if (m_lk >= 0 && req[m_lk]) begin
               w = m_lk;
            end else begin
               m_lk    = -1;
               m_lkcnt = 0;
               w       = -1;
               for (int j = 0; j < N; j++)
                  if (w < 0 && req[(m_rr + j) % N]) w = (m_rr + j) % N;
            end
            m_pend = 1'b1;
            m_own  = w;
            m_addr = addr_a[w];
            m_val  = val_a[w];
         end
      end else if (cs_ready) begin
         m_pend = 1'b0;
         m_cnt[m_own]++;
         if (lock[m_own] && m_lkcnt < ML - 1) begin
            m_lk = m_own;
            m_lkcnt++;
         end else begin
            m_lk    = -1;
            m_lkcnt = 0;
            m_rr    = (m_own + 1) % N;
         end
      end
   endtask

   task automatic check_outputs();
      chk("write_en", 64'(cs_write_en), 64'(m_pend));
      chk("grant",    64'(grant),       m_pend ? onehot(m_own) : 64'd0);
      chk("busy",     64'(busy),        64'(m_pend));
      chk("addr",     64'(cs_pixel_addr),  64'(m_addr));
      chk("value",    64'(cs_pixel_value), 64'(m_val));
      chk("ack",      64'(ack), (m_pend && cs_ready) ? onehot(m_own) : 64'd0);
   endtask

   // One clock: check mid-cycle, advance model, refresh data of acked requesters.
   task automatic cycle();
      #1;
      check_outputs();
      for (int i = 0; i < N; i++) begin
         acked[i] = ack[i];
         if (ack[i]) ack_log.push_back(i);
      end
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acked[i]) begin
            addr_a[i] = 6'($urandom);
            val_a[i]  = 24'($urandom);
            req[i]    = want[i];
         end
      end
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      req      = '0;
      lock     = '0;
      cs_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         want[i]  = 1'b0;
         acked[i] = 1'b0;
      end
      model_reset();
      #1;
      check_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ack_log.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt0, cnt1, lead, cyc;
      logic [5:0]  hold_addr;
      logic [23:0] hold_val;

      for (int i = 0; i < N; i++) begin
         addr_a[i] = '0;
         val_a[i]  = '0;
      end
      @(posedge clk);
      #1;
      do_reset();

      // Single requester latency
      addr_a[0] = 6'd5;
      val_a[0]  = 24'hFF0000;
      req[0]    = 1'b1;
      cs_ready  = 1'b1;
      cycle();
      #1;
      chk("t1_we",    64'(cs_write_en), 64'd1);
      chk("t1_addr",  64'(cs_pixel_addr), 64'd5);
      chk("t1_value", 64'(cs_pixel_value), 64'hFF0000);
      chk("t1_ack",   64'(ack), 64'd1);
      cycle();
      chk("t1_we_off", 64'(cs_write_en), 64'd0);

      // Two continuous requesters alternate
      do_reset();
      want[0] = 1'b1; want[1] = 1'b1;
      addr_a[0] = 6'd10; val_a[0] = 24'h00AA00;
      addr_a[1] = 6'd20; val_a[1] = 24'h0000BB;
      req = 2'b11;
      cs_ready = 1'b1;
      repeat (16) cycle();
      cnt0 = 0; cnt1 = 0;
      foreach (ack_log[k]) if (ack_log[k] == 0) cnt0++; else cnt1++;
      chk("t2_total", 64'(ack_log.size()), 64'd8);
      chk("t2_cnt0",  64'(cnt0), 64'd4);
      chk("t2_cnt1",  64'(cnt1), 64'd4);
      chk("t2_first", 64'(ack_log[0]), 64'd0);
      chk("t2_second", 64'(ack_log[1]), 64'd1);

      // Long stall while cs_ready is low
      do_reset();
      addr_a[0] = 6'd33; val_a[0] = 24'h123456;
      req[0] = 1'b1;
      cycle();
      hold_addr = cs_pixel_addr;
      hold_val  = cs_pixel_value;
      repeat (100) cycle();
      chk("t3_no_ack",    64'(ack_log.size()), 64'd0);
      chk("t3_hold_addr", 64'(cs_pixel_addr), 64'(hold_addr));
      chk("t3_hold_val",  64'(cs_pixel_value), 64'h123456);
      chk("t3_hold_we",   64'(cs_write_en), 64'd1);
      cs_ready = 1'b1;
      #1;
      chk("t3_ack", 64'(ack), 64'd1);
      cycle();

      // Lock with forced rotation after MAX_LOCK accepts
      do_reset();
      want[1] = 1'b1; lock[1] = 1'b1; req[1] = 1'b1;
      cs_ready = 1'b1;
      cycle();
      want[0] = 1'b1; req[0] = 1'b1;
      ack_log.delete();
      cyc = 0;
      while (ack_log.size() < 70 && cyc < 400) begin
         cycle();
         cyc++;
      end
      chk("t4_done", 64'(ack_log.size() >= 70), 64'd1);
      lead = 0;
      while (lead < ack_log.size() && ack_log[lead] == 1) lead++;
      chk("t4_run",   64'(lead), 64'd64);
      chk("t4_rot",   64'(ack_log[64]), 64'd0);
      chk("t4_resume", 64'(ack_log[65]), 64'd1);

      // Asynchronous reset during ISSUE
      do_reset();
      req = 2'b10;
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_we",    64'(cs_write_en), 64'd0);
      chk("t5_grant", 64'(grant), 64'd0);
      chk("t5_busy",  64'(busy), 64'd0);
      chk("t5_ack",   64'(ack), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req = 2'b11;
      cs_ready = 1'b1;
      cycle();
      chk("t5_first", 64'(grant), 64'd1);
      cycle();

      // Request dropped during ISSUE still completes
      do_reset();
      addr_a[0] = 6'd7; val_a[0] = 24'h00FF00;
      req[0] = 1'b1;
      cycle();
      req[0] = 1'b0;
      cs_ready = 1'b1;
      #1;
      chk("t6_ack", 64'(ack), 64'd1);
      cycle();
      cycle();
      chk("t6_idle", 64'(cs_write_en), 64'd0);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            want[i] = ($urandom % 4) != 0;
            if (!req[i] && ($urandom % 2 == 0)) begin
               req[i]    = 1'b1;
               addr_a[i] = 6'($urandom);
               val_a[i]  = 24'($urandom);
            end
            lock[i] = ($urandom % 3) != 0;
         end
         cs_ready = ($urandom % 4) != 0;
         cycle();
      end
`ifdef CS_ARB_STATS_EN
      for (int i = 0; i < N; i++)
         chk("wr_count", 64'(wr_count[i*16 +: 16]), 64'(m_cnt[i]));
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
